// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared encodings for the ALU control / multiply-divide block:
//                ALU select codes, main-control ALU classes, R-type funct
//                values and the MDU sequencer state type.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

   // ALU select presented to the execute-stage ALU
   localparam logic [3:0] ALU_NONE = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_XOR  = 4'd7;
   localparam logic [3:0] ALU_NOR  = 4'd8;

   // ALU class from the main control unit
   localparam logic [2:0] CLS_NONE  = 3'd0;
   localparam logic [2:0] CLS_ADD   = 3'd1;
   localparam logic [2:0] CLS_SUB   = 3'd2;
   localparam logic [2:0] CLS_AND   = 3'd3;
   localparam logic [2:0] CLS_OR    = 3'd4;
   localparam logic [2:0] CLS_SLT   = 3'd5;
   localparam logic [2:0] CLS_RSVD  = 3'd6;
   localparam logic [2:0] CLS_RTYPE = 3'd7;

   // R-type funct field values
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;
   localparam logic [5:0] F_JR    = 6'b001000;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   // Multiply/divide sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter
//  Description : Iterative unsigned multiply (shift-add) / divide (restoring)
//                datapath, one step per clock, WIDTH steps per operation.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                start_i       - load operands and begin (ignored while busy)
//                div_i         - 1 = divide, 0 = multiply (sampled on start)
//                a_i, b_i      - multiplicand/multiplier or dividend/divisor
//                done_o        - final step is taking place this cycle
//                hi_o, lo_o    - result after this cycle's step; valid to
//                                capture when done_o is high
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_iter #(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   // acc_q : running partial product high half / partial remainder
   // low_q : multiplier being shifted out   / dividend shifting into quotient
   // opd_q : multiplicand                   / divisor
   logic             busy_q;
   logic             div_q;
   logic [CNTW-1:0]  cnt_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] low_q;
   logic [WIDTH-1:0] opd_q;

   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   shift_w;
   logic             ge_w;
   logic [WIDTH-1:0] diff_w;
   logic [WIDTH-1:0] step_acc_w;
   logic [WIDTH-1:0] step_low_w;

   always_comb begin
      // Multiply: conditionally add multiplicand, then shift {acc,low} right
      add_w = low_q[0] ? ({1'b0, acc_q} + {1'b0, opd_q}) : {1'b0, acc_q};

      // Divide: shift next dividend bit into the remainder and trial-subtract.
      // The true difference is always below 2^WIDTH when ge_w holds, so the
      // truncated subtraction is exact.
      shift_w = {acc_q, low_q[WIDTH-1]};
      ge_w    = (shift_w >= {1'b0, opd_q});
      diff_w  = shift_w[WIDTH-1:0] - opd_q;

      if (div_q) begin
         step_acc_w = ge_w ? diff_w : shift_w[WIDTH-1:0];
         step_low_w = {low_q[WIDTH-2:0], ge_w};
      end else begin
         step_acc_w = add_w[WIDTH:1];
         step_low_w = {add_w[0], low_q[WIDTH-1:1]};
      end
   end

   assign done_o = busy_q && (cnt_q == CNTW'(WIDTH - 1));
   assign hi_o   = step_acc_w;
   assign lo_o   = step_low_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         low_q  <= '0;
         opd_q  <= '0;
      end else if (busy_q) begin
         acc_q <= step_acc_w;
         low_q <= step_low_w;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end else if (start_i) begin
         busy_q <= 1'b1;
         div_q  <= div_i;
         cnt_q  <= '0;
         acc_q  <= '0;
         low_q  <= div_i ? a_i : b_i;
         opd_q  <= div_i ? b_i : a_i;
      end
   end

endmodule : mdu_iter
`default_nettype wire

// File: rtl/alu_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mdu_ctrl
//  Description : ALU control decode plus sequencing of an iterative unsigned
//                multiply/divide unit with architectural HI/LO registers.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                valid_in              - instruction present this cycle
//                alu_class, funct      - main-control class, R-type funct
//                rs_val, rt_val        - operands
//                alu_sel, jr           - ALU select, jump-register flag
//                stall                 - hold the issuing stage
//                mdu_rd, mdu_out       - MFHI/MFLO result select and value
//                div_zero              - DIVU by zero completed (one cycle)
//                ill_funct             - undecoded R-type funct
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mdu_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [2:0]       alu_class,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic [3:0]       alu_sel,
   output logic             jr,
   output logic             stall,
   output logic             mdu_rd,
   output logic [WIDTH-1:0] mdu_out,
   output logic             div_zero,
   output logic             ill_funct
);

   mdu_state_t       state_q, state_d;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             dz_q;

   logic             is_mfhi_w, is_mflo_w;
   logic             is_start_w, start_div_w;
   logic             mdu_start_w;
   logic             mdu_done_w;
   logic [WIDTH-1:0] mdu_hi_w, mdu_lo_w;

   // ---------------------------------------------------------------- decode
   always_comb begin
      alu_sel     = ALU_NONE;
      jr          = 1'b0;
      ill_funct   = 1'b0;
      is_mfhi_w   = 1'b0;
      is_mflo_w   = 1'b0;
      is_start_w  = 1'b0;
      start_div_w = 1'b0;
      if (valid_in) begin
         case (alu_class)
            CLS_ADD:   alu_sel = ALU_ADD;
            CLS_SUB:   alu_sel = ALU_SUB;
            CLS_AND:   alu_sel = ALU_AND;
            CLS_OR:    alu_sel = ALU_OR;
            CLS_SLT:   alu_sel = ALU_SLT;
            CLS_RTYPE: begin
               case (funct)
                  F_ADD, F_ADDU: alu_sel = ALU_ADD;
                  F_SUB, F_SUBU: alu_sel = ALU_SUB;
                  F_AND:         alu_sel = ALU_AND;
                  F_OR:          alu_sel = ALU_OR;
                  F_XOR:         alu_sel = ALU_XOR;
                  F_NOR:         alu_sel = ALU_NOR;
                  F_SLT:         alu_sel = ALU_SLT;
                  F_SLTU:        alu_sel = ALU_SLTU;
                  F_JR:          jr = 1'b1;
                  F_MFHI:        is_mfhi_w = 1'b1;
                  F_MFLO:        is_mflo_w = 1'b1;
                  F_MULTU:       is_start_w = 1'b1;
                  F_DIVU: begin
                     is_start_w  = 1'b1;
                     start_div_w = 1'b1;
                  end
                  default:       ill_funct = 1'b1;
               endcase
            end
            default:   alu_sel = ALU_NONE;   // none and reserved class
         endcase
      end
   end

   assign mdu_rd  = is_mfhi_w | is_mflo_w;
   assign mdu_out = is_mfhi_w ? hi_q : (is_mflo_w ? lo_q : '0);

   // ----------------------------------------------------------- sequencer
   // A start is only honoured from IDLE: in MUL/DIV/DONE the presented
   // instruction is the held MULTU/DIVU itself and must not re-issue.
   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      mdu_start_w = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_start_w) begin
               stall       = 1'b1;
               mdu_start_w = 1'b1;
               state_d     = start_div_w ? ST_DIV : ST_MUL;
            end
         end
         ST_MUL, ST_DIV: begin
            stall = 1'b1;
            if (mdu_done_w) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign div_zero = (state_q == ST_DONE) && dz_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (mdu_start_w) begin
            dz_q <= start_div_w && (rt_val == '0);
         end
         if ((state_q == ST_MUL || state_q == ST_DIV) && mdu_done_w) begin
            hi_q <= mdu_hi_w;
            lo_q <= mdu_lo_w;
         end
      end
   end

   // -------------------------------------------------------------- datapath
   mdu_iter #(
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
   ) u_mdu_iter (
      .clk     (clk),
      .rst     (rst),
      .start_i (mdu_start_w),
      .div_i   (start_div_w),
      .a_i     (rs_val),
      .b_i     (rt_val),
      .done_o  (mdu_done_w),
      .hi_o    (mdu_hi_w),
      .lo_o    (mdu_lo_w)
   );

endmodule : alu_mdu_ctrl
`default_nettype wire

// File: doc/alu_mdu_ctrl.md
Name: alu_mdu_ctrl

Overview:
- Next-generation ALU control for the multicycle/pipelined MIPS core, parametrised in datapath width.
- Decodes the main-control ALU class and the R-type funct field into an extended ALU select and a JR flag.
- Owns an iterative unsigned multiply/divide unit with architectural HI/LO registers.
- Stalls the issuing stage while a MULTU/DIVU is in flight; MFHI/MFLO read HI/LO.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be ≥4 and even.
- CNTW, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset
- valid_in  input  1  instruction present in decode/execute this cycle
- alu_class  input  3  0 none, 1 add, 2 sub, 3 and, 4 or, 5 slt, 7 R-type (use funct); 6 reserved, treated as none
- funct  input  6  instruction funct field
- rs_val  input  WIDTH  first operand
- rt_val  input  WIDTH  second operand
- alu_sel  output  4  0 none, 1 add, 2 sub, 3 and, 4 or, 5 slt, 6 sltu, 7 xor, 8 nor
- jr  output  1  jump-register decode
- stall  output  1  hold the issuing stage
- mdu_rd  output  1  result mux selects mdu_out (MFHI/MFLO)
- mdu_out  output  WIDTH  HI for MFHI, LO for MFLO, otherwise 0
- div_zero  output  1  one-cycle pulse: DIVU with rt=0 completed
- ill_funct  output  1  R-type funct not decoded (includes signed MULT/DIV)

Behaviour:
- Reset is rst, synchronous, active-high.
  - State→IDLE; HI, LO, counter and operand registers→0.
  - All outputs 0 in the cycle following the reset edge.
  - Reset mid-MUL/DIV aborts the operation with no HI/LO write.
- Decode is combinational and gated by valid_in. With valid_in=0: alu_sel=0, jr=0, mdu_rd=0, ill_funct=0.
- Class decode: classes 1–5 map directly to alu_sel 1–5; class 0/6 gives 0.
- R-type funct decode (class 7):
  - 100000/100001 → 1; 100010/100011 → 2; 100100 → 3; 100101 → 4; 100110 → 7; 100111 → 8; 101010 → 5; 101011 → 6.
  - 001000 → jr=1.
  - 010000 MFHI → mdu_rd=1, mdu_out=HI.
  - 010010 MFLO → mdu_rd=1, mdu_out=LO.
  - 011001 MULTU and 011011 DIVU → start the MDU.
  - Any other funct → ill_funct=1, alu_sel=0.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on valid_in & start funct, stall=1 combinationally that cycle. The edge latches rs/rt, clears the counter, and moves to MUL or DIV.
  - MUL: one shift-add step per cycle, WIDTH cycles, stall=1. At the edge with counter=WIDTH−1, {HI,LO} ← rs×rt (2·WIDTH-bit product); move to DONE.
  - DIV: one restoring step per cycle, WIDTH cycles, stall=1. On the last edge LO ← quotient, HI ← remainder; move to DONE.
  - DONE: stall=0, so the held instruction retires; start decode is suppressed (no re-issue). div_zero=1 here if the divisor was 0. Next edge → IDLE.
- Timing: the issue cycle plus WIDTH busy cycles give WIDTH+1 stall cycles. HI/LO become visible in DONE.
- Divide by zero: no trap. Results are LO=all ones and HI=rs, the natural restoring-algorithm outcome.
- MFHI/MFLO in the DONE cycle see the new HI/LO. Such an instruction cannot be presented earlier, because it is stalled behind the MDU op.
- Decode outputs (alu_sel, jr, ill_funct) follow the presented instruction in every state. The pipeline holds that instruction while stalled.
- Counter wraps never; exit is exact at WIDTH−1.

Decomposition:
- Shared package alu_pkg:
  - alu_sel encodings (ALU_NONE…ALU_NOR);
  - alu_class encodings;
  - funct constants (F_ADD … F_DIVU, F_JR, F_MFHI, F_MFLO);
  - FSM state typedef.
- One sub-module, mdu_iter: the shift-add/restoring datapath.
  - Inputs: start, op, operands.
  - Outputs: done, hi, lo.
- alu_mdu_ctrl keeps decode, the FSM and the HI/LO registers.

Test Plan:
- ALU decode: class 7 with funct 100110, 100111, 101011, 001000, and class 3 → alu_sel 7, 8, 6; jr=1; alu_sel=3; stall=0 throughout.
- MULTU, WIDTH=32, rs=0xFFFFFFFF, rt=0x00000002 → stall high exactly 33 cycles; DONE gives HI=0x00000001, LO=0xFFFFFFFE; following MFLO gives mdu_out=0xFFFFFFFE, mdu_rd=1.
- DIVU rs=100, rt=7 → LO=14, HI=2 after 33 stall cycles; DIVU rs=5, rt=0 → LO=0xFFFFFFFF, HI=5, div_zero pulses exactly once.
- Reset at MUL cycle 10 → next cycle stall=0, state IDLE, HI=LO=0; a new MULTU 3×4 then completes with LO=12.
- funct 011000 (signed MULT) and 111111 → ill_funct=1, stall=0, alu_sel=0, HI/LO unchanged.
- WIDTH=8 instance: MULTU 0xFF×0xFF → HI=0xFE, LO=0x01, stall for 9 cycles.
